// File: rtl/eclock_vma_ctrl.sv
// ============================================================================
//  Module   : eclock_vma_ctrl
//  Function : 6800-style E clock detect/generate and VPA/VMA handshake that
//             returns a one-clock sync_dtack aligned with E to the bus sequencer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module eclock_vma_ctrl #(
    parameter int E_LOW        = 6,
    parameter int E_HIGH       = 4,
    parameter int VMA_SLOT     = 2,
    parameter int DETECT_EDGES = 3
) (
    input  logic c7m,
    input  logic rst_pistorm_mode,
    input  logic m68k_reset_n,
    input  logic bus_granted,
    input  logic s3,
    input  logic s7,
    input  logic vpa_n,
    input  logic e_in,
    output logic e_out,
    output logic e_oe,
    output logic vma_n,
    output logic vma_oe,
    output logic sync_dtack,
    output logic e_ext_present
);

    localparam int E_PERIOD = E_LOW + E_HIGH;
    localparam int CW       = $clog2(E_PERIOD);
    localparam int DW       = $clog2(DETECT_EDGES + 1);

    localparam logic [CW-1:0] E_LAST       = CW'(E_PERIOD - 1);
    localparam logic [CW-1:0] E_HIGH_START = CW'(E_LOW);
    localparam logic [CW-1:0] VMA_AT       = CW'(VMA_SLOT);
    localparam logic [CW-1:0] E_RESYNC     = CW'(1);
    localparam logic [DW-1:0] DET_MAX      = DW'(DETECT_EDGES);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT_E = 2'd1;
    localparam logic [1:0] ST_VMA    = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    logic          e_meta_q, e_s_q, e_s_d_q;
    logic          e_fall;
    logic [CW-1:0] e_cnt_q, e_cnt_d;
    logic [DW-1:0] edge_cnt_q, edge_cnt_d;
    logic          e_oe_q, e_oe_d;
    logic          reset_d_q;
    logic [1:0]    state_q, state_d;
    logic          vma_n_q, vma_n_d;
    logic          sync_dtack_q, sync_dtack_d;
    logic          e_last;
    logic          abort;

    // Synchroniser flops reset low so that leaving reset never fakes an E fall.
    always_ff @(posedge c7m or posedge rst_pistorm_mode) begin
        if (rst_pistorm_mode) begin
            e_meta_q <= 1'b0;
            e_s_q    <= 1'b0;
            e_s_d_q  <= 1'b0;
        end else begin
            e_meta_q <= e_in;
            e_s_q    <= e_meta_q;
            e_s_d_q  <= e_s_q;
        end
    end

    assign e_fall        = e_s_d_q & ~e_s_q;
    assign e_last        = (e_cnt_q == E_LAST);
    assign e_ext_present = (edge_cnt_q == DET_MAX);
    assign abort         = ~bus_granted | ~m68k_reset_n;

    always_comb begin
        e_cnt_d    = e_cnt_q + CW'(1);
        edge_cnt_d = edge_cnt_q;
        e_oe_d     = e_oe_q;
        if (!e_oe_q && e_fall) begin
            e_cnt_d = E_RESYNC;
        end else if (e_last) begin
            e_cnt_d = '0;
        end
        // Our own E must never be counted as evidence of a host E.
        if (!e_oe_q && e_fall && (edge_cnt_q != DET_MAX)) begin
            edge_cnt_d = edge_cnt_q + DW'(1);
        end
        if (!reset_d_q && m68k_reset_n) begin
            e_oe_d = ~e_ext_present;
        end
    end

    always_ff @(posedge c7m or posedge rst_pistorm_mode) begin
        if (rst_pistorm_mode) begin
            e_cnt_q    <= '0;
            edge_cnt_q <= '0;
            e_oe_q     <= 1'b0;
            reset_d_q  <= 1'b0;
        end else begin
            e_cnt_q    <= e_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            e_oe_q     <= e_oe_d;
            reset_d_q  <= m68k_reset_n;
        end
    end

    always_ff @(posedge c7m or posedge rst_pistorm_mode) begin
        if (rst_pistorm_mode) begin
            state_q      <= ST_IDLE;
            vma_n_q      <= 1'b1;
            sync_dtack_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            vma_n_q      <= vma_n_d;
            sync_dtack_q <= sync_dtack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   if (s3 && !vpa_n)          state_d = ST_WAIT_E;
                ST_WAIT_E: if (e_cnt_q == VMA_AT)     state_d = ST_VMA;
                ST_VMA:    if (e_last)                state_d = ST_DONE;
                ST_DONE:   if (s7)                    state_d = ST_IDLE;
                default:                              state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        vma_n_d      = ~((state_d == ST_VMA) || (state_d == ST_DONE));
        sync_dtack_d = (state_q == ST_VMA) && e_last && !abort;
    end

    assign e_out      = (e_cnt_q >= E_HIGH_START);
    assign e_oe       = e_oe_q;
    assign vma_n      = vma_n_q;
    assign vma_oe     = bus_granted;
    assign sync_dtack = sync_dtack_q;

endmodule

`default_nettype wire
